// File: rtl/cis_splitter.sv
// cis_splitter: sits between instruction prefetch and decode.
// Takes one fetched 32-bit word at a time and hands decode one instruction
// per handshake. Words with bit 31 set are compressed (CIS) words and carry
// two 15-bit half-instructions, issued upper half first.
// Build option: define OPT_CIS_EN to enable splitting. Without it, any
// non-faulting word with bit 31 set is passed through whole and flagged
// illegal, and o_cis/o_phase are tied low.
module cis_splitter #(
   parameter int ADDRESS_WIDTH = 32
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_new_pc,
   input  logic                     i_clear_cache,
   input  logic                     i_half_start,
   input  logic                     i_pf_valid,
   input  logic [31:0]              i_pf_insn,
   input  logic [ADDRESS_WIDTH-1:0] i_pf_pc,
   input  logic                     i_pf_illegal,
   output logic                     o_pf_stalled_n,
   input  logic                     i_stalled_n,
   output logic                     o_valid,
   output logic [31:0]              o_insn,
   output logic [ADDRESS_WIDTH-1:0] o_pc,
   output logic                     o_phase,
   output logic                     o_cis,
   output logic                     o_illegal
);

   localparam int AW = ADDRESS_WIDTH;

   logic          valid_reg,   valid_next;
   logic [31:0]   insn_reg,    insn_next;
   logic [AW-1:0] pc_reg,      pc_next;
   logic          illegal_reg, illegal_next;

   logic flush;
   logic advance;
   logic load;
   logic pending_now;

   // A flush from either source kills whatever is held or outstanding
   assign flush   = i_new_pc || i_clear_cache;
   // Output register may be overwritten when empty or when decode takes it
   assign advance = !valid_reg || i_stalled_n;

`ifdef OPT_CIS_EN
   logic          phase_reg,   phase_next;
   logic          cis_reg,     cis_next;
   logic          pending_reg, pending_next;
   logic [14:0]   half_reg,    half_next;
   logic          skip_reg,    skip_next;

   assign pending_now = pending_reg;
`else
   // Branch-into-second-half has no meaning without splitting
   logic unused_half_start;
   assign unused_half_start = i_half_start;
   assign pending_now       = 1'b0;
`endif

   // Prefetch word is taken only when the output slot frees up, no second
   // half is still owed, and nothing is flushing the pipe this cycle
   assign o_pf_stalled_n = advance && !pending_now && !flush && !i_rst;
   assign load           = i_pf_valid && o_pf_stalled_n;

`ifdef OPT_CIS_EN
   // Next-state: flush beats second-half issue, which beats a new load
   always_comb begin
      valid_next   = valid_reg;
      insn_next    = insn_reg;
      pc_next      = pc_reg;
      illegal_next = illegal_reg;
      phase_next   = phase_reg;
      cis_next     = cis_reg;
      pending_next = pending_reg;
      half_next    = half_reg;
      skip_next    = skip_reg;

      if (flush) begin
         valid_next   = 1'b0;
         illegal_next = 1'b0;
         pending_next = 1'b0;
         // Landing on the second half of a CIS word: drop its upper half
         skip_next    = i_new_pc && i_half_start;
      end else if (pending_reg && advance) begin
         valid_next   = 1'b1;
         insn_next    = {1'b1, half_reg, 16'h0000};
         phase_next   = 1'b1;
         cis_next     = 1'b1;
         illegal_next = 1'b0;
         pending_next = 1'b0;
      end else if (load) begin
         valid_next = 1'b1;
         pc_next    = i_pf_pc;
         skip_next  = 1'b0;
         if (i_pf_illegal) begin
            // A faulted fetch is never split; decode must see the fault once
            insn_next    = i_pf_insn;
            illegal_next = 1'b1;
            phase_next   = 1'b0;
            cis_next     = 1'b0;
         end else if (!i_pf_insn[31]) begin
            insn_next    = i_pf_insn;
            illegal_next = 1'b0;
            phase_next   = 1'b0;
            cis_next     = 1'b0;
         end else if (!skip_reg) begin
            insn_next    = {1'b1, i_pf_insn[30:16], 16'h0000};
            illegal_next = 1'b0;
            phase_next   = 1'b0;
            cis_next     = 1'b1;
            pending_next = 1'b1;
            half_next    = i_pf_insn[14:0];
         end else begin
            insn_next    = {1'b1, i_pf_insn[14:0], 16'h0000};
            illegal_next = 1'b0;
            phase_next   = 1'b1;
            cis_next     = 1'b1;
         end
      end else if (advance) begin
         valid_next = 1'b0;
      end
   end

   // Registers for the output slot and the split bookkeeping
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_reg   <= 1'b0;
         insn_reg    <= '0;
         pc_reg      <= '0;
         illegal_reg <= 1'b0;
         phase_reg   <= 1'b0;
         cis_reg     <= 1'b0;
         pending_reg <= 1'b0;
         half_reg    <= '0;
         skip_reg    <= 1'b0;
      end else begin
         valid_reg   <= valid_next;
         insn_reg    <= insn_next;
         pc_reg      <= pc_next;
         illegal_reg <= illegal_next;
         phase_reg   <= phase_next;
         cis_reg     <= cis_next;
         pending_reg <= pending_next;
         half_reg    <= half_next;
         skip_reg    <= skip_next;
      end
   end

   assign o_phase = phase_reg;
   assign o_cis   = cis_reg;
`else
   // Next-state without splitting: a CIS-form word is an illegal instruction
   always_comb begin
      valid_next   = valid_reg;
      insn_next    = insn_reg;
      pc_next      = pc_reg;
      illegal_next = illegal_reg;

      if (flush) begin
         valid_next   = 1'b0;
         illegal_next = 1'b0;
      end else if (load) begin
         valid_next   = 1'b1;
         insn_next    = i_pf_insn;
         pc_next      = i_pf_pc;
         illegal_next = i_pf_illegal || i_pf_insn[31];
      end else if (advance) begin
         valid_next = 1'b0;
      end
   end

   // Registers for the output slot
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_reg   <= 1'b0;
         insn_reg    <= '0;
         pc_reg      <= '0;
         illegal_reg <= 1'b0;
      end else begin
         valid_reg   <= valid_next;
         insn_reg    <= insn_next;
         pc_reg      <= pc_next;
         illegal_reg <= illegal_next;
      end
   end

   assign o_phase = 1'b0;
   assign o_cis   = 1'b0;
`endif

   assign o_valid   = valid_reg;
   assign o_insn    = insn_reg;
   assign o_pc      = pc_reg;
   assign o_illegal = illegal_reg;

endmodule

// File: tb/tb_cis_splitter.sv
// Bench for cis_splitter: directed steps followed by random traffic, all
// checked against a queue-based reference model of the instruction stream.
module tb_cis_splitter;

   localparam int AW = 32;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_new_pc = 1'b0;
   logic          i_clear_cache = 1'b0;
   logic          i_half_start = 1'b0;
   logic          i_pf_valid = 1'b0;
   logic [31:0]   i_pf_insn = '0;
   logic [AW-1:0] i_pf_pc = '0;
   logic          i_pf_illegal = 1'b0;
   logic          o_pf_stalled_n;
   logic          i_stalled_n = 1'b1;
   logic          o_valid;
   logic [31:0]   o_insn;
   logic [AW-1:0] o_pc;
   logic          o_phase;
   logic          o_cis;
   logic          o_illegal;

   int n_assert = 0;
   int n_fail   = 0;

   cis_splitter #(.ADDRESS_WIDTH(AW)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_new_pc       (i_new_pc),
      .i_clear_cache  (i_clear_cache),
      .i_half_start   (i_half_start),
      .i_pf_valid     (i_pf_valid),
      .i_pf_insn      (i_pf_insn),
      .i_pf_pc        (i_pf_pc),
      .i_pf_illegal   (i_pf_illegal),
      .o_pf_stalled_n (o_pf_stalled_n),
      .i_stalled_n    (i_stalled_n),
      .o_valid        (o_valid),
      .o_insn         (o_insn),
      .o_pc           (o_pc),
      .o_phase        (o_phase),
      .o_cis          (o_cis),
      .o_illegal      (o_illegal)
   );

   always #5 i_clk = ~i_clk;

   // Reference model: the instruction presented to decode plus a queue of
   // instructions already fetched but not yet presented.
   typedef struct packed {
      logic [31:0]   insn;
      logic [AW-1:0] pc;
      logic          phase;
      logic          cis;
      logic          illegal;
   } ins_t;

   ins_t m_out;
   logic m_valid;
   ins_t m_q[$];
   logic m_skip;
   int   n_issued;

   function automatic logic [31:0] half_word(input logic [14:0] h);
      logic [31:0] w;
      w = {1'b1, h, 16'h0000};
      return w;
   endfunction

   function automatic logic model_take();
      return (!m_valid || i_stalled_n) && (m_q.size() == 0) &&
             !i_new_pc && !i_clear_cache && !i_rst;
   endfunction

   // Turn one fetched word into the instruction(s) decode should see
   task automatic expand(output ins_t first, output logic two, output ins_t second);
      first   = '{insn: i_pf_insn, pc: i_pf_pc, phase: 1'b0, cis: 1'b0, illegal: i_pf_illegal};
      second  = first;
      two     = 1'b0;
`ifdef OPT_CIS_EN
      if (!i_pf_illegal && i_pf_insn[31]) begin
         first.cis = 1'b1;
         if (m_skip) begin
            first.insn  = half_word(i_pf_insn[14:0]);
            first.phase = 1'b1;
         end else begin
            first.insn   = half_word(i_pf_insn[30:16]);
            second       = first;
            second.insn  = half_word(i_pf_insn[14:0]);
            second.phase = 1'b1;
            two          = 1'b1;
         end
      end
`else
      if (i_pf_insn[31]) first.illegal = 1'b1;
`endif
   endtask

   task automatic model_clock();
      ins_t f, s;
      logic two;
      logic take;
      take = model_take() && i_pf_valid;
      if (i_rst) begin
         m_valid = 1'b0;
         m_out   = '0;
         m_q.delete();
         m_skip  = 1'b0;
      end else if (i_new_pc || i_clear_cache) begin
         m_valid       = 1'b0;
         m_out.illegal = 1'b0;
         m_q.delete();
`ifdef OPT_CIS_EN
         m_skip = i_new_pc && i_half_start;
`endif
      end else if ((!m_valid || i_stalled_n) && m_q.size() > 0) begin
         m_out   = m_q.pop_front();
         m_valid = 1'b1;
         n_issued++;
      end else if (take) begin
         expand(f, two, s);
         m_out   = f;
         m_valid = 1'b1;
         m_skip  = 1'b0;
         if (two) m_q.push_back(s);
         n_issued++;
      end else if (!m_valid || i_stalled_n) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check the combinational stall, clock, check outputs
   task automatic cycle(input logic rst, input logic npc, input logic clr, input logic hs,
                        input logic pfv, input logic [31:0] insn, input logic [AW-1:0] pc,
                        input logic ill, input logic stn);
      i_rst = rst; i_new_pc = npc; i_clear_cache = clr; i_half_start = hs;
      i_pf_valid = pfv; i_pf_insn = insn; i_pf_pc = pc; i_pf_illegal = ill;
      i_stalled_n = stn;
      @(negedge i_clk);
      if (!rst && (m_valid === 1'b1 || m_valid === 1'b0))
         chk("pf_stalled_n", {63'd0, o_pf_stalled_n}, {63'd0, model_take()});
      @(posedge i_clk);
      model_clock();
      #1;
      chk("valid", {63'd0, o_valid}, {63'd0, m_valid});
      if (m_valid) begin
         chk("insn", {32'd0, o_insn}, {32'd0, m_out.insn});
         chk("pc", {32'd0, o_pc}, {32'd0, m_out.pc});
         chk("phase", {63'd0, o_phase}, {63'd0, m_out.phase});
         chk("cis", {63'd0, o_cis}, {63'd0, m_out.cis});
         chk("illegal", {63'd0, o_illegal}, {63'd0, m_out.illegal});
      end
      $display("t=%0t rst=%0b npc=%0b clr=%0b pfv=%0b insn=%h stn=%0b -> v=%0b insn=%h pc=%h ph=%0b cis=%0b ill=%0b",
               $time, rst, npc, clr, pfv, insn, stn, o_valid, o_insn, o_pc, o_phase, o_cis, o_illegal);
   endtask

   initial begin
      m_valid  = 1'b0;
      m_out    = '0;
      m_skip   = 1'b0;
      n_issued = 0;

      // Reset: everything cleared
      cycle(1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1);
      cycle(1, 0, 0, 0, 1, 32'h1234_5678, 32'h40, 0, 1);
      chk("rst_valid", {63'd0, o_valid}, 64'd0);
      chk("rst_insn", {32'd0, o_insn}, 64'd0);
      chk("rst_pc", {32'd0, o_pc}, 64'd0);
      chk("rst_flags", {61'd0, o_phase, o_cis, o_illegal}, 64'd0);

      // Plain word, single-cycle latency
      cycle(0, 0, 0, 0, 1, 32'h0123_4567, 32'h100, 0, 1);
      chk("plain_insn", {32'd0, o_insn}, 64'h0123_4567);

      // CIS word, then another word that must wait during the second half
      cycle(0, 0, 0, 0, 1, 32'h8AAA_5555, 32'h200, 0, 1);
`ifdef OPT_CIS_EN
      chk("cis_hi", {32'd0, o_insn}, 64'h8AAA_0000);
`else
      chk("cis_off_ill", {63'd0, o_illegal}, 64'd1);
`endif
      cycle(0, 0, 0, 0, 1, 32'h0000_0011, 32'h204, 0, 1);
`ifdef OPT_CIS_EN
      chk("cis_lo", {32'd0, o_insn}, 64'hD555_0000);
`endif
      cycle(0, 0, 0, 0, 1, 32'h0000_0011, 32'h204, 0, 1);
      cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1);

      // Decoder stalled while first half is held, then released
      cycle(0, 0, 0, 0, 1, 32'h8AAA_5555, 32'h300, 0, 1);
      repeat (3) cycle(0, 0, 0, 0, 1, 32'h0000_0022, 32'h304, 0, 0);
      cycle(0, 0, 0, 0, 1, 32'h0000_0022, 32'h304, 0, 1);
      cycle(0, 0, 0, 0, 1, 32'h0000_0022, 32'h304, 0, 1);

      // Flush while a second half is pending
      cycle(0, 0, 0, 0, 1, 32'h8333_4444, 32'h400, 0, 1);
      cycle(0, 1, 0, 0, 1, 32'h0000_0033, 32'h404, 0, 1);
      cycle(0, 0, 0, 0, 1, 32'h0000_0055, 32'h800, 0, 1);

      // Branch into the second half of a CIS word
      cycle(0, 1, 0, 1, 0, 32'h0, 32'h0, 0, 1);
      cycle(0, 0, 0, 0, 1, 32'h8111_2222, 32'h900, 0, 1);
`ifdef OPT_CIS_EN
      chk("skip_lo", {32'd0, o_insn}, 64'hA222_0000);
`endif
      cycle(0, 0, 0, 0, 1, 32'h0000_0066, 32'h904, 0, 1);

      // Fetch faults and CIS-form words with splitting disabled
      cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'hA00, 1, 1);
      chk("fault_ill", {62'd0, o_illegal, o_cis}, 64'd2);
      cycle(0, 0, 0, 0, 1, 32'h8000_0001, 32'hA04, 0, 1);
      cycle(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 1);
      cycle(0, 0, 1, 0, 0, 32'h0, 32'h0, 0, 1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) != 0), $urandom, $urandom,
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
      end

      chk("issued_some", {63'd0, (n_issued > 500)}, 64'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cis_splitter.md
Name: cis_splitter

Overview:
- Sits directly downstream of the instruction prefetch and upstream of the instruction decoder.
- Consumes one fetched 32-bit word at a time and presents one instruction per handshake to decode.
- When a word is in compressed instruction set (CIS) form (bit 31 set), it splits the word into two 15-bit half-instructions issued in order.
- Owns the backpressure signal that drives the prefetch's stall-not input.

Parameters:
- ADDRESS_WIDTH, 32, width of the word address carried with each instruction (AW).

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous, active-high reset
- i_new_pc  input  1  branch/flush; kills held and pending instructions
- i_clear_cache  input  1  flush; same effect as i_new_pc here
- i_half_start  input  1  sampled with i_new_pc: branch target is the second half of a CIS word
- i_pf_valid  input  1  prefetch word valid
- i_pf_insn  input  32  prefetch instruction word
- i_pf_pc  input  AW  word address of i_pf_insn
- i_pf_illegal  input  1  bus error on fetch
- o_pf_stalled_n  output  1  word consumed from prefetch this cycle when high with i_pf_valid
- i_stalled_n  input  1  decoder accepts o_* this cycle
- o_valid  output  1  instruction valid to decode
- o_insn  output  32  full word, or {1'b1, half[14:0], 16'h0000} for a CIS half
- o_pc  output  AW  word address of source word
- o_phase  output  1  1 = second half of a CIS word
- o_cis  output  1  o_insn is a CIS half
- o_illegal  output  1  instruction carries a fetch bus error

Behaviour:
- Reset: o_valid, o_phase, o_cis, o_illegal = 0; o_insn, o_pc = 0; pending = 0; skip = 0.
- Internal state:
  - pending (second half outstanding), with held lower half [14:0].
  - skip flag, set by i_new_pc with i_half_start, cleared on the next load.
- advance = !o_valid || i_stalled_n.
- o_pf_stalled_n = advance && !pending && !i_new_pc && !i_clear_cache. Combinational.
- Load occurs when i_pf_valid && o_pf_stalled_n. Outputs register next cycle (latency 1):
  - i_pf_illegal: emit whole word once. o_illegal=1, o_cis=0, o_phase=0. Never split.
  - i_pf_insn[31]=0: emit word unchanged. o_cis=0, o_phase=0.
  - i_pf_insn[31]=1, skip=0: emit upper half [30:16]. o_cis=1, o_phase=0; pending<=1, latch [14:0].
  - i_pf_insn[31]=1, skip=1: emit lower half directly. o_cis=1, o_phase=1; pending stays 0.
  - skip=1 with a non-CIS word: word emitted normally, skip cleared.
- Second-half issue: pending && advance → emit latched half with o_phase=1, o_cis=1, same o_pc; pending<=0.
- No advance: all o_* hold stable. Decoder sees no change until it accepts.
- Idle: advance with no load and no pending → o_valid<=0.
- Throughput:
  - Non-CIS words: 1 per cycle with decode never stalled.
  - CIS words: 2 cycles each; prefetch is stalled during the second-half cycle.
- i_rst, i_new_pc, or i_clear_cache: o_valid<=0, o_illegal<=0, pending<=0 next cycle. Any word presented that cycle is not consumed.
- Precedence: reset > flush > second-half issue > load.

Optional Feature:
- OPT_CIS_EN
  - Defined: splitting as above.
  - Undefined: no splitting, pending logic removed, o_cis and o_phase tied 0, i_half_start ignored. Any non-illegal word with bit 31 set is emitted whole with o_illegal=1.

Test Plan:
- Reset then i_pf_valid=1, insn=32'h0123_4567, pc=0x100, i_stalled_n=1 → next cycle o_valid=1, o_insn=32'h0123_4567, o_pc=0x100, o_cis=0; o_pf_stalled_n=1 throughout.
- insn=32'h8AAA_5555, pc=0x200 → cycle+1: o_insn=32'h8AAA_0000 (half 0x0AAA), o_phase=0. Cycle+2: o_insn=32'hD555_0000 (half 0x5555), o_phase=1, o_pc=0x200. o_pf_stalled_n=0 during cycle+1.
- Decoder stalled (i_stalled_n=0) for 3 cycles while first half is held → outputs stable, o_pf_stalled_n=0, no word consumed. Release → second half issues next cycle.
- i_new_pc pulse while pending=1 → o_valid=0 next cycle; second half never issued; next word from new pc loads normally.
- i_new_pc with i_half_start=1, then insn=32'h8111_2222 → single output with half 0x2222, o_phase=1, followed by the next word.
- i_pf_illegal=1 with insn=32'hFFFF_FFFF → one output with o_illegal=1, o_cis=0. With OPT_CIS_EN undefined, insn=32'h8000_0001 → one output with o_illegal=1.
